// File: rtl/osd_event_depacketization.sv
// Receive side of the OSD event stream: strips DI headers and reassembles one event from 1..N packets.
// Optional macro OSD_EVENT_DEPKT_SRC_CHECK_EN: drop continuation packets whose SRC differs from the first packet.
module osd_event_depacketization #(
    parameter int MAX_PKT_LEN        = 12,
    parameter int MAX_DATA_NUM_WORDS = 8,
    localparam int CNT_W = $clog2(MAX_DATA_NUM_WORDS + 1),
    localparam int IDX_W = (MAX_DATA_NUM_WORDS > 1) ? $clog2(MAX_DATA_NUM_WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id,
    input  logic             debug_in_valid,
    input  logic [15:0]      debug_in_data,
    input  logic             debug_in_last,
    output logic             debug_in_ready,
    output logic             event_valid,
    input  logic             event_ready,
    output logic [15:0]      event_src,
    output logic             event_overflow,
    output logic [CNT_W-1:0] event_num_words,
    input  logic [IDX_W-1:0] data_rd_idx,
    output logic [15:0]      data_rd,
    output logic             err_drop
);

    // state   | meaning
    // DEST    | expecting destination header flit
    // SRC     | expecting source header flit
    // FLAGS   | expecting type/subtype flit
    // PAYLOAD | storing payload words of a LAST/CONTINUE packet
    // OVF     | storing the single word of an overflow packet
    // DROP    | discarding flits until end of packet
    // EVT_OUT | event held for consumer, input stalled
    localparam logic [2:0] S_DEST    = 3'd0;
    localparam logic [2:0] S_SRC     = 3'd1;
    localparam logic [2:0] S_FLAGS   = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_OVF     = 3'd4;
    localparam logic [2:0] S_DROP    = 3'd5;
    localparam logic [2:0] S_EVT_OUT = 3'd6;

    localparam int PCW = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_DATA_NUM_WORDS);
    localparam logic [PCW-1:0]   PAY_MAX  = PCW'(MAX_PKT_LEN - 3);

    logic [2:0]       state;
    logic             dest_match;
    logic             mode_last;
    logic             overflow;
    logic [15:0]      pkt_src;
    logic [15:0]      first_src;
    logic [CNT_W-1:0] word_cnt;
    logic [PCW-1:0]   pay_cnt;
    logic [15:0]      buffer [MAX_DATA_NUM_WORDS];
    logic             flit_acc;
    logic             pending;
    logic             src_bad;
    logic [CNT_W:0]   idx_ext;

    assign debug_in_ready  = !rst && (state != S_EVT_OUT);
    assign flit_acc        = debug_in_valid && debug_in_ready;
    assign event_valid     = (state == S_EVT_OUT);
    assign event_src       = first_src;
    assign event_overflow  = overflow;
    assign event_num_words = word_cnt;
    assign pending         = (word_cnt != '0);

`ifdef OSD_EVENT_DEPKT_SRC_CHECK_EN
    assign src_bad = pending && (pkt_src != first_src);
`else
    assign src_bad = 1'b0;
`endif

    assign idx_ext = (CNT_W + 1)'(data_rd_idx);

    always_comb begin
        data_rd = 16'h0000;
        if (idx_ext < {1'b0, word_cnt})
            data_rd = buffer[data_rd_idx];
    end

    // Buffer has no reset; reads are masked by word_cnt so stale words never leak.
    always_ff @(posedge clk) begin
        if (!rst && flit_acc) begin
            if (state == S_PAYLOAD && word_cnt != FULL_CNT)
                buffer[word_cnt[IDX_W-1:0]] <= debug_in_data;
            else if (state == S_OVF)
                buffer[0] <= debug_in_data;
        end
    end

    always_ff @(posedge clk) begin
        err_drop <= 1'b0;
        if (rst) begin
            state      <= S_DEST;
            dest_match <= 1'b0;
            mode_last  <= 1'b0;
            overflow   <= 1'b0;
            pkt_src    <= 16'h0000;
            first_src  <= 16'h0000;
            word_cnt   <= '0;
            pay_cnt    <= '0;
        end else if (state == S_EVT_OUT) begin
            if (event_ready) begin
                word_cnt <= '0;
                overflow <= 1'b0;
                state    <= S_DEST;
            end
        end else if (flit_acc) begin
            case (state)
                S_DEST: begin
                    dest_match <= (debug_in_data == id);
                    if (debug_in_last) begin
                        err_drop <= 1'b1;
                        word_cnt <= '0;
                        overflow <= 1'b0;
                    end else begin
                        state <= S_SRC;
                    end
                end
                S_SRC: begin
                    pkt_src <= debug_in_data;
                    if (debug_in_last) begin
                        err_drop <= 1'b1;
                        word_cnt <= '0;
                        overflow <= 1'b0;
                        state    <= S_DEST;
                    end else begin
                        state <= S_FLAGS;
                    end
                end
                S_FLAGS: begin
                    if (debug_in_last) begin
                        err_drop <= 1'b1;
                        word_cnt <= '0;
                        overflow <= 1'b0;
                        state    <= S_DEST;
                    end else if (debug_in_data[15:14] != 2'b10 || !dest_match) begin
                        err_drop <= 1'b1;
                        word_cnt <= '0;
                        overflow <= 1'b0;
                        state    <= S_DROP;
                    end else if (debug_in_data[13:10] == 4'd0 || debug_in_data[13:10] == 4'd1) begin
                        if (src_bad) begin
                            err_drop <= 1'b1;
                            word_cnt <= '0;
                            overflow <= 1'b0;
                            state    <= S_DROP;
                        end else begin
                            if (!pending)
                                first_src <= pkt_src;
                            mode_last <= (debug_in_data[13:10] == 4'd0);
                            pay_cnt   <= '0;
                            state     <= S_PAYLOAD;
                        end
                    end else if (debug_in_data[13:10] == 4'd5) begin
                        // A pending continuation is lost, but the overflow event itself proceeds.
                        if (pending) begin
                            err_drop <= 1'b1;
                            word_cnt <= '0;
                        end
                        first_src <= pkt_src;
                        state     <= S_OVF;
                    end else begin
                        err_drop <= 1'b1;
                        word_cnt <= '0;
                        overflow <= 1'b0;
                        state    <= S_DROP;
                    end
                end
                S_PAYLOAD: begin
                    if (word_cnt == FULL_CNT || pay_cnt == PAY_MAX) begin
                        err_drop <= 1'b1;
                        word_cnt <= '0;
                        overflow <= 1'b0;
                        state    <= debug_in_last ? S_DEST : S_DROP;
                    end else begin
                        word_cnt <= word_cnt + CNT_W'(1);
                        pay_cnt  <= pay_cnt + PCW'(1);
                        if (debug_in_last)
                            state <= mode_last ? S_EVT_OUT : S_DEST;
                    end
                end
                S_OVF: begin
                    if (debug_in_last) begin
                        word_cnt <= CNT_W'(1);
                        overflow <= 1'b1;
                        state    <= S_EVT_OUT;
                    end else begin
                        err_drop <= 1'b1;
                        word_cnt <= '0;
                        overflow <= 1'b0;
                        state    <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (debug_in_last)
                        state <= S_DEST;
                end
                default: state <= S_DEST;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_event_depacketization.sv
// Directed bench for osd_event_depacketization: single/multi-packet events, overflow, drops, backpressure.
module tb_osd_event_depacketization;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] id = 16'h0004;
    logic        debug_in_valid = 1'b0;
    logic [15:0] debug_in_data = 16'h0000;
    logic        debug_in_last = 1'b0;
    logic        debug_in_ready;
    logic        event_valid;
    logic        event_ready = 1'b0;
    logic [15:0] event_src;
    logic        event_overflow;
    logic [3:0]  event_num_words;
    logic [2:0]  data_rd_idx = 3'd0;
    logic [15:0] data_rd;
    logic        err_drop;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int err_base;
    logic [15:0] pkt[$];

    osd_event_depacketization #(.MAX_PKT_LEN(12), .MAX_DATA_NUM_WORDS(8)) dut (
        .clk(clk), .rst(rst), .id(id),
        .debug_in_valid(debug_in_valid), .debug_in_data(debug_in_data),
        .debug_in_last(debug_in_last), .debug_in_ready(debug_in_ready),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_src(event_src), .event_overflow(event_overflow),
        .event_num_words(event_num_words), .data_rd_idx(data_rd_idx),
        .data_rd(data_rd), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && err_drop) err_cnt <= err_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_flit(input logic [15:0] d, input logic l);
        int n = 0;
        debug_in_valid = 1'b1;
        debug_in_data  = d;
        debug_in_last  = l;
        while (!debug_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("ready_wait", debug_in_ready, 1);
        @(posedge clk); #1;
        debug_in_valid = 1'b0;
        debug_in_last  = 1'b0;
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_flit(pkt[i], i == pkt.size() - 1);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [15:0] exp);
        data_rd_idx = idx;
        #1;
        chk(tag, data_rd, exp);
    endtask

    task automatic pop();
        event_ready = 1'b1;
        @(posedge clk); #1;
        event_ready = 1'b0;
        chk("pop_valid", event_valid, 0);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", debug_in_ready, 0);
        chk("rst_valid", event_valid, 0);
        chk("rst_ovf", event_overflow, 0);
        chk("rst_src", event_src, 0);
        chk("rst_nw", event_num_words, 0);
        chk("rst_err", err_drop, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", debug_in_ready, 1);

        // single 3-word event
        pkt = '{16'h0004, 16'h0002, 16'h8000, 16'h000A, 16'h000B, 16'h000C};
        send_pkt();
        chk("t1_valid", event_valid, 1);
        chk("t1_src", event_src, 16'h0002);
        chk("t1_nw", event_num_words, 3);
        chk("t1_ovf", event_overflow, 0);
        rd_chk("t1_rd0", 0, 16'h000A);
        rd_chk("t1_rd1", 1, 16'h000B);
        rd_chk("t1_rd2", 2, 16'h000C);
        rd_chk("t1_rd3", 3, 16'h0000);
        pop();
        chk("t1_nw_clr", event_num_words, 0);

        // three-packet continuation
        pkt = '{16'h0004, 16'h0003, 16'h8400, 16'h0001, 16'h0002}; send_pkt();
        pkt = '{16'h0004, 16'h0003, 16'h8400, 16'h0003, 16'h0004}; send_pkt();
        chk("t2_mid_valid", event_valid, 0);
        pkt = '{16'h0004, 16'h0003, 16'h8000, 16'h0005}; send_pkt();
        chk("t2_valid", event_valid, 1);
        chk("t2_nw", event_num_words, 5);
        chk("t2_src", event_src, 16'h0003);
        for (int i = 0; i < 5; i++) rd_chk("t2_rd", 3'(i), 16'(i + 1));
        pop();

        // overflow event
        pkt = '{16'h0004, 16'h0002, 16'h9400, 16'h0007}; send_pkt();
        chk("t3_valid", event_valid, 1);
        chk("t3_ovf", event_overflow, 1);
        chk("t3_nw", event_num_words, 1);
        rd_chk("t3_rd0", 0, 16'h0007);
        pop();
        chk("t3_ovf_clr", event_overflow, 0);

        // foreign destination dropped, next packet normal
        err_base = err_cnt;
        pkt = '{16'h0009, 16'h0002, 16'h8000, 16'h000A, 16'h000B, 16'h000C}; send_pkt();
        settle();
        chk("t4_valid", event_valid, 0);
        chk("t4_err", err_cnt - err_base, 1);
        pkt = '{16'h0004, 16'h0002, 16'h8000, 16'h0011}; send_pkt();
        chk("t4_next_valid", event_valid, 1);
        rd_chk("t4_next_rd0", 0, 16'h0011);

        // backpressure: event held, new DEST flit waiting
        begin
            int ready_seen = 0;
            debug_in_valid = 1'b1;
            debug_in_data  = 16'h0004;
            debug_in_last  = 1'b0;
            repeat (10) begin
                @(posedge clk); #1;
                if (debug_in_ready) ready_seen++;
            end
            chk("t5_ready_low", ready_seen, 0);
            rd_chk("t5_hold_rd0", 0, 16'h0011);
            chk("t5_hold_nw", event_num_words, 1);
            event_ready = 1'b1;
            @(posedge clk); #1;
            event_ready = 1'b0;
            chk("t5_ready_back", debug_in_ready, 1);
            @(posedge clk); #1;
            pkt = '{16'h0002, 16'h8000, 16'h000D}; send_pkt();
            chk("t5_valid", event_valid, 1);
            chk("t5_nw", event_num_words, 1);
            rd_chk("t5_rd0", 0, 16'h000D);
            pop();
        end

        // 9 words into an 8-word buffer
        err_base = err_cnt;
        pkt = '{16'h0004, 16'h0002, 16'h8000};
        for (int i = 1; i <= 9; i++) pkt.push_back(16'(i));
        send_pkt();
        settle();
        chk("t6_valid", event_valid, 0);
        chk("t6_err", err_cnt - err_base, 1);
        chk("t6_nw", event_num_words, 0);

        // malformed headers and drop of a pending partial
        err_base = err_cnt;
        pkt = '{16'h0004, 16'h0002}; send_pkt();
        pkt = '{16'h0004, 16'h0002, 16'h4000, 16'h0001}; send_pkt();
        pkt = '{16'h0004, 16'h0002, 16'h8400, 16'h0001, 16'h0002}; send_pkt();
        pkt = '{16'h0009, 16'h0002, 16'h8000, 16'h0003}; send_pkt();
        settle();
        chk("t7_err", err_cnt - err_base, 3);
        chk("t7_nw", event_num_words, 0);
        chk("t7_valid", event_valid, 0);

        // overflow while a continuation is pending
        err_base = err_cnt;
        pkt = '{16'h0004, 16'h0002, 16'h8400, 16'h0001}; send_pkt();
        pkt = '{16'h0004, 16'h0005, 16'h9400, 16'h0007}; send_pkt();
        chk("t8_valid", event_valid, 1);
        chk("t8_ovf", event_overflow, 1);
        chk("t8_src", event_src, 16'h0005);
        chk("t8_nw", event_num_words, 1);
        rd_chk("t8_rd0", 0, 16'h0007);
        pop();
        settle();
        chk("t8_err", err_cnt - err_base, 1);

        // continuation with a different SRC
        err_base = err_cnt;
        pkt = '{16'h0004, 16'h0002, 16'h8400, 16'h0001, 16'h0002}; send_pkt();
        pkt = '{16'h0004, 16'h0003, 16'h8000, 16'h0003}; send_pkt();
`ifdef OSD_EVENT_DEPKT_SRC_CHECK_EN
        chk("t9_valid", event_valid, 0);
        settle();
        chk("t9_err", err_cnt - err_base, 1);
`else
        chk("t9_valid", event_valid, 1);
        chk("t9_src", event_src, 16'h0002);
        chk("t9_nw", event_num_words, 3);
        rd_chk("t9_rd2", 2, 16'h0003);
        pop();
        settle();
        chk("t9_err", err_cnt - err_base, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
